// File: rtl/bell_measure_unit_pkg.sv
// Shared constants and FSM encoding for the two-qubit measurement datapath.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bell_measure_unit_pkg;

  localparam int AMP_W  = 32;
  localparam int FRAC_W = 16;

  localparam logic [AMP_W-1:0] FIXED_ONE  = 32'h0001_0000;
  localparam logic [AMP_W-1:0] FIXED_ZERO = 32'h0000_0000;
  localparam logic [AMP_W-1:0] INV_SQRT2  = 32'h0000_B505;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SQ    = 3'd1,
    S_SCALE = 3'd2,
    S_CMP   = 3'd3,
    S_OUT   = 3'd4
  } state_t;

endpackage

// File: rtl/bell_measure_unit_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR, x^16+x^14+x^13+x^11+1, advanced every clock.
// Latency: value is the current register state; the next state appears one edge later.
// Backpressure: none; it never stalls.
// Ports: clk, rst (sync, active-high, loads seed), seed (zero is mapped to 1), value (current state).
module lfsr16 (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] seed,
  output logic [15:0] value
);

  logic fb;

  // Right-shifting form: the taps of x^16, x^14, x^13, x^11 sit at bits 0, 2, 3, 5.
  assign fb = value[0] ^ value[2] ^ value[3] ^ value[5];

  always_ff @(posedge clk) begin
    if (rst) begin
      value <= (seed == 16'h0000) ? 16'h0001 : seed;
    end else begin
      value <= {fb, value[15:1]};
    end
  end

endmodule

// File: rtl/bell_measure_unit.sv
// Turns four Q16.16 amplitudes into Born-rule probabilities, draws one outcome per request, keeps histograms.
// Latency: request accepted at edge E0, out_valid rises after E6 (4 square cycles, scale, compare).
// Backpressure: in_ready only in IDLE; the result is held stable in OUT until out_ready.
// Ports: clk, rst (sync, active-high); in_valid/in_ready + state_xx_in (signed Q16.16);
//        out_valid/out_ready + outcome {q1,q0}, prob_total (Q18.16), norm_err;
//        hist_clr (clears all counters), hist_00..hist_11 (saturating outcome counts).
module bell_measure_unit
  import bell_measure_unit_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter logic [31:0] NORM_TOL  = 32'h0000_0100,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [AMP_W-1:0] state_00_in,
  input  logic [AMP_W-1:0] state_01_in,
  input  logic [AMP_W-1:0] state_10_in,
  input  logic [AMP_W-1:0] state_11_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       outcome,
  output logic [33:0]      prob_total,
  output logic             norm_err,
  input  logic             hist_clr,
  output logic [CNT_W-1:0] hist_00,
  output logic [CNT_W-1:0] hist_01,
  output logic [CNT_W-1:0] hist_10,
  output logic [CNT_W-1:0] hist_11
);

  state_t state, state_nxt;

  logic [1:0]             idx;
  logic signed [AMP_W-1:0] amp [4];
  logic [33:0]            cum [4];
  logic                   sat;
  logic [33:0]            thr;
  logic [15:0]            rnd;
  logic [CNT_W-1:0]       hist [4];

  // Datapath wires
  logic signed [AMP_W-1:0] cur_amp;
  logic signed [63:0]      sq;
  logic [47:0]             sq_shr;
  logic                    sq_ovf;
  logic [31:0]             p;
  logic [33:0]             cum_prev;
  logic [49:0]             scale_prod;
  logic [1:0]              sel;
  logic [34:0]             tot_ext, one_ext, tol_ext;
  logic                    norm_bad;

  lfsr16 u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .seed  (LFSR_SEED),
    .value (rnd)
  );

  // One shared signed multiplier; the square is never negative, so only the
  // integer bits above Q16.16 range signal overflow.
  assign cur_amp  = amp[idx];
  assign sq       = 64'(cur_amp) * 64'(cur_amp);
  assign sq_shr   = 48'(sq >> FRAC_W);
  assign sq_ovf   = (sq_shr[47:32] != 16'h0000);
  assign p        = sq_ovf ? 32'hFFFF_FFFF : sq_shr[31:0];
  assign cum_prev = (idx == 2'd0) ? 34'd0 : cum[idx - 2'd1];

  // rnd is Q0.16, so the threshold is strictly below the total for any nonzero total.
  assign scale_prod = 50'(rnd) * 50'(cum[3]);

  // Smallest k whose cumulative sum exceeds the threshold; zero-probability
  // slots never satisfy it because their cum equals the previous one.
  always_comb begin
    sel = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (thr < cum[k]) sel = 2'(k);
    end
  end

  // One extra bit so total+tol cannot wrap near the top of the 34-bit range.
  assign tot_ext  = {1'b0, cum[3]};
  assign one_ext  = 35'(FIXED_ONE);
  assign tol_ext  = 35'(NORM_TOL);
  assign norm_bad = sat || ((tot_ext + tol_ext) < one_ext) || (tot_ext > (one_ext + tol_ext));

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = S_SQ;
      end
      S_SQ:    if (idx == 2'd3) state_nxt = S_SCALE;
      S_SCALE: state_nxt = S_CMP;
      S_CMP:   state_nxt = S_OUT;
      S_OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx        <= 2'd0;
      sat        <= 1'b0;
      thr        <= 34'd0;
      outcome    <= 2'd0;
      prob_total <= 34'd0;
      norm_err   <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        amp[k] <= FIXED_ZERO;
        cum[k] <= 34'd0;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            amp[0] <= state_00_in;
            amp[1] <= state_01_in;
            amp[2] <= state_10_in;
            amp[3] <= state_11_in;
            idx    <= 2'd0;
            sat    <= 1'b0;
          end
        end
        S_SQ: begin
          cum[idx] <= cum_prev + {2'b00, p};
          if (sq_ovf) sat <= 1'b1;
          idx <= idx + 2'd1;
        end
        S_SCALE: thr <= 34'(scale_prod >> 16);
        S_CMP: begin
          outcome    <= sel;
          prob_total <= cum[3];
          norm_err   <= norm_bad;
        end
        default: ;
      endcase
    end
  end

  // A clear in the same cycle as a compare-stage increment wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) hist[k] <= '0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (hist_clr) begin
          hist[k] <= '0;
        end else if (state == S_CMP && sel == 2'(k) && hist[k] != '1) begin
          hist[k] <= hist[k] + 1'b1;
        end
      end
    end
  end

  assign hist_00 = hist[0];
  assign hist_01 = hist[1];
  assign hist_10 = hist[2];
  assign hist_11 = hist[3];

endmodule

// File: tb/tb_bell_measure_unit.sv
// Self-checking bench for bell_measure_unit against a behavioural probability model.
// Latency: checks out_valid rising exactly after the sixth edge following acceptance.
// Backpressure: exercises held results with out_ready low and inputs toggling while busy.
module tb_bell_measure_unit;
  import bell_measure_unit_pkg::*;

  localparam int          CW   = 10;
  localparam logic [15:0] SEED = 16'hACE1;
  localparam int          HMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic hist_clr = 1'b0;
  logic [31:0] a00 = '0, a01 = '0, a10 = '0, a11 = '0;
  logic in_ready, out_valid, norm_err;
  logic [1:0] outcome;
  logic [33:0] prob_total;
  logic [CW-1:0] h00, h01, h10, h11;

  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] m_lfsr;
  int m_hist [4];
  logic [31:0] amp [4];

  always #5 clk = ~clk;

  bell_measure_unit #(
    .LFSR_SEED (SEED),
    .NORM_TOL  (32'h0000_0100),
    .CNT_W     (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .state_00_in (a00),
    .state_01_in (a01),
    .state_10_in (a10),
    .state_11_in (a11),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .outcome     (outcome),
    .prob_total  (prob_total),
    .norm_err    (norm_err),
    .hist_clr    (hist_clr),
    .hist_00     (h00),
    .hist_01     (h01),
    .hist_10     (h10),
    .hist_11     (h11)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // Polynomial x^16+x^14+x^13+x^11+1 in right-shifting form: exponent e taps bit 16-e.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    int taps [4];
    logic fb;
    taps = '{16, 14, 13, 11};
    fb = 1'b0;
    for (int i = 0; i < 4; i++) fb ^= s[16 - taps[i]];
    return {fb, s[15:1]};
  endfunction

  always @(posedge clk) begin
    if (rst) m_lfsr <= SEED;
    else     m_lfsr <= lfsr_step(m_lfsr);
  end

  // Born-rule probabilities, cumulative threshold and tolerance check from plain arithmetic.
  task automatic model(input logic [15:0] rnd, output logic [1:0] oc,
                       output logic [33:0] tot, output logic ne);
    longint sq, pk, thr;
    longint cumv [4];
    bit sat;
    sat = 0;
    tot = 0;
    for (int k = 0; k < 4; k++) begin
      sq = longint'($signed(amp[k])) * longint'($signed(amp[k]));
      if ((sq >> 48) != 0) begin
        pk  = 64'hFFFF_FFFF;
        sat = 1;
      end else begin
        pk = (sq >> 16) & 64'hFFFF_FFFF;
      end
      cumv[k] = ((k == 0) ? 0 : cumv[k-1]) + pk;
    end
    tot = 34'(cumv[3]);
    thr = (longint'(rnd) * cumv[3]) >> 16;
    oc = 2'd0;
    for (int k = 3; k >= 0; k--) if (thr < cumv[k]) oc = 2'(k);
    ne = sat || (cumv[3] < 64'h1_0000 - 64'h100) || (cumv[3] > 64'h1_0000 + 64'h100);
  endtask

  task automatic check_hist(input string tag);
    chk({tag, "_h00"}, h00, m_hist[0]);
    chk({tag, "_h01"}, h01, m_hist[1]);
    chk({tag, "_h10"}, h10, m_hist[2]);
    chk({tag, "_h11"}, h11, m_hist[3]);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_outcome"}, outcome, 0);
    chk({tag, "_total"}, prob_total, 0);
    chk({tag, "_norm_err"}, norm_err, 0);
    for (int k = 0; k < 4; k++) m_hist[k] = 0;
    check_hist(tag);
  endtask

  task automatic clear_hist();
    @(negedge clk);
    hist_clr = 1'b1;
    @(posedge clk);
    #1;
    hist_clr = 1'b0;
    for (int k = 0; k < 4; k++) m_hist[k] = 0;
    check_hist("clr");
  endtask

  // One full request: accept, checked latency, optional hold and clear-at-compare, handshake.
  task automatic shot(input logic [31:0] v0, input logic [31:0] v1, input logic [31:0] v2,
                      input logic [31:0] v3, input int hold, input bit clr_at_cmp, input string tag);
    logic [15:0] rnd;
    logic [1:0]  e_oc;
    logic [33:0] e_tot;
    logic        e_ne;
    int          w;
    @(negedge clk);
    amp[0] = v0; amp[1] = v1; amp[2] = v2; amp[3] = v3;
    a00 = v0; a01 = v1; a10 = v2; a11 = v3;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    w = 0;
    while (!in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      chk({tag, "_idle_timeout"}, in_ready, 1);
      in_valid = 1'b0;
      out_ready = 1'b1;
      return;
    end
    @(posedge clk);
    #1;
    // in_valid stays high with garbage data while busy: it must be ignored.
    a00 = $urandom; a01 = $urandom; a10 = $urandom; a11 = $urandom;
    chk({tag, "_busy_rdy"}, in_ready, 0);
    repeat (4) @(posedge clk);
    #1;
    rnd = m_lfsr;
    @(posedge clk);
    #1;
    chk({tag, "_early_vld"}, out_valid, 0);
    if (clr_at_cmp) hist_clr = 1'b1;
    @(posedge clk);
    #1;
    hist_clr = 1'b0;
    in_valid = 1'b0;
    model(rnd, e_oc, e_tot, e_ne);
    if (clr_at_cmp) begin
      for (int k = 0; k < 4; k++) m_hist[k] = 0;
    end else if (m_hist[e_oc] < HMAX) begin
      m_hist[e_oc]++;
    end
    chk({tag, "_vld"}, out_valid, 1);
    chk({tag, "_outcome"}, outcome, e_oc);
    chk({tag, "_total"}, prob_total, e_tot);
    chk({tag, "_norm_err"}, norm_err, e_ne);
    check_hist(tag);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk({tag, "_hold_vld"}, out_valid, 1);
      chk({tag, "_hold_oc"}, outcome, e_oc);
      chk({tag, "_hold_tot"}, prob_total, e_tot);
      chk({tag, "_hold_rdy"}, in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk({tag, "_done_vld"}, out_valid, 0);
    chk({tag, "_done_rdy"}, in_ready, 1);
  endtask

  function automatic logic [31:0] rand_amp();
    logic [31:0] v;
    case ($urandom_range(0, 3))
      0:       v = 32'h0;
      1:       v = 32'($urandom_range(0, 32'h1_8000));
      2:       v = -32'($urandom_range(0, 32'h1_8000));
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset("reset");
    rst = 1'b0;

    for (int i = 0; i < 20; i++) shot(FIXED_ONE, 0, 0, 0, 0, 0, "one00");
    chk("one00_count", h00, 20);

    for (int i = 0; i < 10; i++) shot(0, 0, 0, FIXED_ONE, 0, 0, "one11");

    shot(32'h0002_0000, 0, 0, 0, 0, 0, "big00");
    chk("big00_total", prob_total, 34'h4_0000);
    shot(0, 32'h0100_0000, 0, 0, 0, 0, "sat01");
    chk("sat01_err", norm_err, 1);

    shot(INV_SQRT2, 0, 0, INV_SQRT2, 10, 0, "bp");

    clear_hist();
    for (int i = 0; i < 1000; i++) shot(INV_SQRT2, 0, 0, INV_SQRT2, 0, 0, "bell");
    chk("bell_total", prob_total, 34'h1_0000);
    chk("bell_h01_zero", h01, 0);
    chk("bell_h10_zero", h10, 0);
    chk("bell_h00_range", (h00 >= 400 && h00 <= 600), 1);
    chk("bell_h11_range", (h11 >= 400 && h11 <= 600), 1);

    for (int i = 0; i < 150; i++)
      shot(rand_amp(), rand_amp(), rand_amp(), rand_amp(), $urandom_range(0, 3), 0, "rand");

    shot(FIXED_ONE, 0, 0, 0, 0, 1, "clr_cmp");
    chk("clr_cmp_h00", h00, 0);

    // Reset while the square stage is working on index 2.
    shot(FIXED_ONE, 0, 0, 0, 0, 0, "pre_rst");
    @(negedge clk);
    a00 = FIXED_ONE; a01 = 0; a10 = 0; a11 = 0;
    chk("mid_rst_idle", in_ready, 1);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_reset("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      chk("mid_rst_no_vld", out_valid, 0);
    end
    check_hist("mid_rst_after");

    clear_hist();
    for (int i = 0; i < HMAX + 7; i++) shot(FIXED_ONE, 0, 0, 0, 0, 0, "satcnt");
    chk("satcnt_h00", h00, HMAX);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
